// File: rtl/serial_adder.sv
// serial_adder: digit-serial WIDTH-bit adder with carry-in.
// One DIGIT-wide adder slice is reused N = WIDTH/DIGIT times, with the carry
// held in a register between iterations. Operands are taken through a
// valid/ready handshake, and the sum is handed back through another one.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c,
   output logic             ovf,
   output logic             busy
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Refuse to build a configuration that cannot be iterated evenly.
   generate
      if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   logic [1:0]       state_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             carry_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0] s_reg;
   logic             c_reg;
   logic             ovf_reg;

   logic [DIGIT:0]   sum_slice;
   logic             msb_carry_in;
   logic [WIDTH-1:0] acc_next;
   logic             last_digit;

   // One DIGIT-wide slice of the addition, including the registered carry.
   always_comb begin
      sum_slice = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry_reg};
      // The carry into the top bit of the slice can be recovered from that
      // bit's sum and its two operand bits.
      msb_carry_in = sum_slice[DIGIT-1] ^ a_reg[DIGIT-1] ^ b_reg[DIGIT-1];
      // The newest digit enters at the top. After N shifts, the first digit
      // has reached bit 0.
      acc_next = (acc_reg >> DIGIT)
               | (WIDTH'(sum_slice[DIGIT-1:0]) << (WIDTH - DIGIT));
      last_digit = (cnt_reg == CW'(N - 1));
   end

   // Sequencer and datapath. The result registers are written only at completion.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         cnt_reg   <= '0;
         acc_reg   <= '0;
         s_reg     <= '0;
         c_reg     <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  carry_reg <= c_in;
                  cnt_reg   <= '0;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               a_reg     <= a_reg >> DIGIT;
               b_reg     <= b_reg >> DIGIT;
               carry_reg <= sum_slice[DIGIT];
               acc_reg   <= acc_next;
               cnt_reg   <= cnt_reg + 1'b1;
               if (last_digit) begin
                  s_reg     <= acc_next;
                  c_reg     <= sum_slice[DIGIT];
                  ovf_reg   <= msb_carry_in ^ sum_slice[DIGIT];
                  state_reg <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Handshake flags are decoded directly from the state.
   always_comb begin
      in_ready  = (state_reg == IDLE);
      out_valid = (state_reg == DONE);
      busy      = (state_reg != IDLE);
      s         = s_reg;
      c         = c_reg;
      ovf       = ovf_reg;
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: checks four serial_adder configurations that share one handshake.
// The configurations are 8/1, 8/2, 8/8 and 16/4.
// Expected values come from hand-computed vector rows and from an
// integer-arithmetic reference model.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst_n;
   logic in_valid;
   logic out_ready;
   logic c_in;
   logic [7:0]  a8, b8;
   logic [15:0] a16, b16;

   logic        vld [4];
   logic        rdy [4];
   logic        bsy [4];
   logic        co  [4];
   logic        ov  [4];
   logic [7:0]  s8  [3];
   logic [15:0] s16;

   int n_vec = 0;
   int n_err = 0;
   int lat_exp [4] = '{8, 4, 1, 4};

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
      .a(a8), .b(b8), .c_in(c_in), .out_valid(vld[0]), .out_ready(out_ready),
      .s(s8[0]), .c(co[0]), .ovf(ov[0]), .busy(bsy[0]));

   serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
      .a(a8), .b(b8), .c_in(c_in), .out_valid(vld[1]), .out_ready(out_ready),
      .s(s8[1]), .c(co[1]), .ovf(ov[1]), .busy(bsy[1]));

   serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
      .a(a8), .b(b8), .c_in(c_in), .out_valid(vld[2]), .out_ready(out_ready),
      .s(s8[2]), .c(co[2]), .ovf(ov[2]), .busy(bsy[2]));

   serial_adder #(.WIDTH(16), .DIGIT(4)) u_w16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]),
      .a(a16), .b(b16), .c_in(c_in), .out_valid(vld[3]), .out_ready(out_ready),
      .s(s16), .c(co[3]), .ovf(ov[3]), .busy(bsy[3]));

   typedef struct {
      logic [7:0]  a, b;
      logic        ci;
      logic [7:0]  s;
      logic        c, ov;
      logic [15:0] aw, bw, sw;
      logic        cw, ovw;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer addition, with signed overflow found by range check.
   task automatic model(input int w, input longint x, input longint y, input int ci,
                        output longint sum, output int cout, output int ovo);
      longint full, half, tot, sx, sy, sv;
      full = longint'(1) << w;
      half = full >> 1;
      tot  = x + y + ci;
      sum  = tot % full;
      cout = int'(tot / full);
      sx   = (x >= half) ? x - full : x;
      sy   = (y >= half) ? y - full : y;
      sv   = sx + sy + ci;
      ovo  = (sv >= half || sv < -half) ? 1 : 0;
   endtask

   // Present one operand set for exactly one accept edge, then scramble the inputs.
   task automatic start_op(input logic [7:0] av, input logic [7:0] bv,
                           input logic [15:0] awv, input logic [15:0] bwv, input logic civ);
      a8 = av; b8 = bv; a16 = awv; b16 = bwv; c_in = civ;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); c_in = 1'($urandom);
   endtask

   // Wait, with a bound, until every instance shows out_valid, and record each latency.
   task automatic wait_done(output int lat [4]);
      int e;
      bit all;
      e = 0;
      for (int i = 0; i < 4; i++) lat[i] = -1;
      all = 0;
      while (!all && e < 40) begin
         @(posedge clk); #1;
         e++;
         all = 1;
         for (int i = 0; i < 4; i++) begin
            if (vld[i] && lat[i] < 0) lat[i] = e;
            if (!vld[i]) all = 0;
         end
      end
      if (!all) check("timeout_out_valid", 32'd0, 32'd1);
   endtask

   task automatic check_results(input string tag, input logic [7:0] es, input logic ec,
                                input logic eo, input logic [15:0] ews, input logic ewc,
                                input logic ewo, input int lat [4]);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_s8[%0d]", tag, i), 32'(s8[i]), 32'(es));
         check($sformatf("%s_c8[%0d]", tag, i), 32'(co[i]), 32'(ec));
         check($sformatf("%s_ovf8[%0d]", tag, i), 32'(ov[i]), 32'(eo));
      end
      check({tag, "_s16"}, 32'(s16), 32'(ews));
      check({tag, "_c16"}, 32'(co[3]), 32'(ewc));
      check({tag, "_ovf16"}, 32'(ov[3]), 32'(ewo));
      for (int i = 0; i < 4; i++)
         check($sformatf("%s_latency[%0d]", tag, i), 32'(lat[i]), 32'(lat_exp[i]));
   endtask

   // One consume edge; afterwards every instance must be idle and ready again.
   task automatic consume(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_consumed_valid[%0d]", tag, i), 32'(vld[i]), 32'd0);
         check($sformatf("%s_consumed_ready[%0d]", tag, i), 32'(rdy[i]), 32'd1);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat [4];
      longint ms;
      int mc, mo;
      longint ws;
      int wc, wo;
      logic [7:0] ra, rb;
      logic [15:0] rwa, rwb;
      logic rci;
      int stall;

      tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
      tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
      tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
      tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
      tbl[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
      tbl[6] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1, 16'h00FF, 16'h0001, 16'h0101, 1'b0, 1'b0};
      tbl[7] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0, 16'hABCD, 16'h5432, 16'h0000, 1'b1, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; c_in = 1'b0;
      a8 = '0; b8 = '0; a16 = '0; b16 = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("reset_in_ready[%0d]", i), 32'(rdy[i]), 32'd1);
         check($sformatf("reset_out_valid[%0d]", i), 32'(vld[i]), 32'd0);
         check($sformatf("reset_busy[%0d]", i), 32'(bsy[i]), 32'd0);
         check($sformatf("reset_c[%0d]", i), 32'(co[i]), 32'd0);
         check($sformatf("reset_ovf[%0d]", i), 32'(ov[i]), 32'd0);
      end
      for (int i = 0; i < 3; i++) check($sformatf("reset_s8[%0d]", i), 32'(s8[i]), 32'd0);
      check("reset_s16", 32'(s16), 32'd0);

      // Directed vector table.
      for (int r = 0; r < 8; r++) begin
         start_op(tbl[r].a, tbl[r].b, tbl[r].aw, tbl[r].bw, tbl[r].ci);
         check($sformatf("tbl%0d_busy_run", r), 32'(bsy[0]), 32'd1);
         check($sformatf("tbl%0d_in_ready_run", r), 32'(rdy[0]), 32'd0);
         wait_done(lat);
         check_results($sformatf("tbl%0d", r), tbl[r].s, tbl[r].c, tbl[r].ov,
                       tbl[r].sw, tbl[r].cw, tbl[r].ovw, lat);
         consume($sformatf("tbl%0d", r));
      end

      // Backpressure: the result holds, and new operands offered during the stall are ignored.
      start_op(8'h7F, 8'h01, 16'hFFFF, 16'h0001, 1'b0);
      wait_done(lat);
      for (int k = 0; k < 5; k++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
         in_valid = 1'b1;
         @(posedge clk); #1;
         check_results($sformatf("stall%0d", k), 8'h80, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, lat);
         for (int i = 0; i < 4; i++) begin
            check($sformatf("stall%0d_in_ready[%0d]", k, i), 32'(rdy[i]), 32'd0);
            check($sformatf("stall%0d_out_valid[%0d]", k, i), 32'(vld[i]), 32'd1);
         end
      end
      in_valid = 1'b0;
      consume("bp");
      repeat (3) begin
         @(posedge clk); #1;
         for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_once_valid[%0d]", i), 32'(vld[i]), 32'd0);
            check($sformatf("bp_once_busy[%0d]", i), 32'(bsy[i]), 32'd0);
         end
      end

      // Reset asserted while the 8/1 instance is in RUN with counter 3.
      start_op(8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 1'b1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("midrst_out_valid[%0d]", i), 32'(vld[i]), 32'd0);
         check($sformatf("midrst_in_ready[%0d]", i), 32'(rdy[i]), 32'd1);
         check($sformatf("midrst_busy[%0d]", i), 32'(bsy[i]), 32'd0);
      end
      for (int i = 0; i < 3; i++) check($sformatf("midrst_s8[%0d]", i), 32'(s8[i]), 32'd0);
      check("midrst_s16", 32'(s16), 32'd0);
      start_op(8'h12, 8'h34, 16'h0012, 16'h0034, 1'b0);
      wait_done(lat);
      check_results("post_rst", 8'h46, 1'b0, 1'b0, 16'h0046, 1'b0, 1'b0, lat);
      consume("post_rst");

      // Random operands with random consumer stalls, checked against the model.
      for (int t = 0; t < 1200; t++) begin
         ra = 8'($urandom); rb = 8'($urandom);
         rwa = 16'($urandom); rwb = 16'($urandom); rci = 1'($urandom);
         stall = $urandom_range(0, 3);
         model(8, longint'(ra), longint'(rb), int'(rci), ms, mc, mo);
         model(16, longint'(rwa), longint'(rwb), int'(rci), ws, wc, wo);
         start_op(ra, rb, rwa, rwb, rci);
         wait_done(lat);
         repeat (stall) begin
            @(posedge clk); #1;
         end
         check_results($sformatf("rnd%0d", t), 8'(ms), 1'(mc), 1'(mo),
                       16'(ws), 1'(wc), 1'(wo), lat);
         consume($sformatf("rnd%0d", t));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
